// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
// The IF/LS owner encoding and FSM state codes live here.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    // LS wins a grant unless IF is also waiting and has been starved long enough.
    function automatic logic pick_ls(input logic if_req, input logic ls_req, input logic starved);
        return ls_req && !(if_req && starved);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, the memory port and the arbiter.
// Requests are levels held until the matching done pulse; mem_ready is a one-cycle completion pulse.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              mux_sel;
    logic [DATA_W-1:0] rdata;
    logic              if_done;
    logic              ls_done;
    logic              err;
    logic              busy;

    modport master (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mux_sel, rdata, if_done, ls_done, err, busy
    );

    modport slave (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mux_sel, rdata, if_done, ls_done, err, busy
    );

endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; at_max flags count == MAX.
// Used for the IF starvation streak and the access timeout.
module sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign at_max = (cnt_q == MAX_V);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// sequencing IDLE -> ACCESS -> RESP with a starvation guard and an access timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.master   bus,
    output state_e               dbg_state
);
    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic winner_ls;
    logic streak_inc, streak_clr, streak_at_max;
    logic timer_inc, timer_clr, timer_at_max;

    sat_counter #(.WIDTH(4), .MAX(STARVE_MAX)) u_streak (
        .clk    (clk),
        .rst_n  (reset),
        .inc    (streak_inc),
        .clr    (streak_clr),
        .at_max (streak_at_max)
    );

    // Timer starts at the grant so it equals the ACCESS cycle number during ACCESS.
    sat_counter #(.WIDTH(8), .MAX(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (reset),
        .inc    (timer_inc),
        .clr    (timer_clr),
        .at_max (timer_at_max)
    );

    assign winner_ls = pick_ls(bus.if_req, bus.ls_req, streak_at_max);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        streak_inc = 1'b0;
        streak_clr = 1'b0;
        timer_inc  = 1'b0;
        timer_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.if_req || bus.ls_req) begin
                    owner_d   = winner_ls ? OWNER_LS : OWNER_IF;
                    we_d      = winner_ls && bus.ls_we;
                    addr_d    = winner_ls ? bus.ls_addr : bus.if_addr;
                    wdata_d   = winner_ls ? bus.ls_wdata : '0;
                    timer_inc = 1'b1;
                    state_d   = ST_ACCESS;
                    if (winner_ls && bus.if_req) begin
                        streak_inc = 1'b1;
                    end else begin
                        streak_clr = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                timer_inc = 1'b1;
                if (bus.mem_ready) begin
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timer_at_max) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                timer_clr = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // In IDLE the select previews the pending winner so the port mux settles before ACCESS.
    assign bus.mux_sel   = (state_q == ST_IDLE) ? (winner_ls && reset) : owner_q;
    assign bus.mem_req   = (state_q == ST_ACCESS);
    assign bus.mem_we    = (state_q == ST_ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
    assign bus.if_done   = (state_q == ST_RESP) && (owner_q == OWNER_IF);
    assign bus.ls_done   = (state_q == ST_RESP) && (owner_q == OWNER_LS);
    assign bus.busy      = (state_q != ST_IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner-case sequences,
// and randomized transactions against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int STARVE = 4;
  localparam int TMO    = 255;

  logic   clk;
  logic   reset;
  state_e dbg_state;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE), .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic clear_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.ls_req    = 1'b0;
    bus.ls_we     = 1'b0;
    bus.ls_addr   = '0;
    bus.ls_wdata  = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1 with the DUT idle. k = ACCESS cycle carrying mem_ready (0 = never).
  task automatic do_access(
    input  logic ireq, input logic lreq, input logic lwe,
    input  logic [31:0] iaddr, input logic [31:0] laddr,
    input  logic [31:0] lwdata, input logic [31:0] mrdata, input int k,
    output int req_cycles, output logic mux_idle, output logic mux_acc, output logic we_acc,
    output logic [31:0] addr_acc, output logic [31:0] wdata_acc,
    output int if_cnt, output int ls_cnt, output logic err_o, output logic [31:0] rdata_o,
    output logic tail_bad, output logic timed_out);
    bus.if_req    = ireq;
    bus.if_addr   = iaddr;
    bus.ls_req    = lreq;
    bus.ls_we     = lwe;
    bus.ls_addr   = laddr;
    bus.ls_wdata  = lwdata;
    bus.mem_rdata = mrdata;
    bus.mem_ready = 1'b0;
    #1;
    mux_idle   = bus.mux_sel;
    req_cycles = 0;
    if_cnt     = 0;
    ls_cnt     = 0;
    timed_out  = 1'b1;
    mux_acc    = 1'b0;
    we_acc     = 1'b0;
    addr_acc   = '0;
    wdata_acc  = '0;
    err_o      = 1'b0;
    rdata_o    = '0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (bus.if_done) if_cnt++;
      if (bus.ls_done) ls_cnt++;
      if (bus.mem_req) begin
        req_cycles++;
        if (req_cycles == 1) begin
          mux_acc   = bus.mux_sel;
          we_acc    = bus.mem_we;
          addr_acc  = bus.mem_addr;
          wdata_acc = bus.mem_wdata;
        end
        bus.mem_ready = (k != 0) && (req_cycles == k);
      end else begin
        bus.mem_ready = 1'b0;
      end
      if (bus.if_done || bus.ls_done) begin
        err_o     = bus.err;
        rdata_o   = bus.rdata;
        timed_out = 1'b0;
        break;
      end
    end
    bus.if_req    = 1'b0;
    bus.ls_req    = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    tail_bad = bus.if_done | bus.ls_done | bus.busy | bus.mem_req;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ireq;
    logic        lreq;
    logic        lwe;
    logic [31:0] iaddr;
    logic [31:0] laddr;
    logic [31:0] lwdata;
    logic [31:0] mrdata;
    int          k;
    int          exp_cycles;
    logic        exp_own;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic run_and_check(input string tag, input vec_t v);
    int          cyc, ic, lc;
    logic        mi, ma, wa, e, tb_, to;
    logic [31:0] aa, wd, rd;
    do_access(v.ireq, v.lreq, v.lwe, v.iaddr, v.laddr, v.lwdata, v.mrdata, v.k,
              cyc, mi, ma, wa, aa, wd, ic, lc, e, rd, tb_, to);
    check({tag, " timeout_bound"}, 64'(to), 64'(0));
    check({tag, " mem_req_cycles"}, 64'(cyc), 64'(v.exp_cycles));
    check({tag, " mux_sel_idle"}, 64'(mi), 64'(v.exp_own));
    check({tag, " mux_sel_access"}, 64'(ma), 64'(v.exp_own));
    check({tag, " mem_we"}, 64'(wa), 64'(v.exp_we));
    check({tag, " mem_addr"}, 64'(aa), 64'(v.exp_addr));
    if (v.exp_we) check({tag, " mem_wdata"}, 64'(wd), 64'(v.exp_wdata));
    check({tag, " if_done_count"}, 64'(ic), 64'(v.exp_own ? 0 : 1));
    check({tag, " ls_done_count"}, 64'(lc), 64'(v.exp_own ? 1 : 0));
    check({tag, " err"}, 64'(e), 64'(v.exp_err));
    check({tag, " rdata"}, 64'(rd), 64'(v.exp_rdata));
    check({tag, " idle_after_done"}, 64'(tb_), 64'(0));
  endtask

  // ---------------- test body ----------------
  initial begin
    int          done_cnt;
    int          grants;
    logic        got_own[$];
    int          streak_m;
    logic [31:0] rdata_m;

    vecs[0] = '{1, 0, 0, 32'h100, 32'h0,   32'h0,        32'hDEADBEEF, 2, 2,   0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0};
    vecs[1] = '{0, 1, 1, 32'h0,   32'h200, 32'h12345678, 32'hFFFF0000, 1, 1,   1, 1, 32'h200, 32'h12345678, 32'hDEADBEEF, 0};
    vecs[2] = '{0, 1, 0, 32'h0,   32'h300, 32'h0000AAAA, 32'hCAFEF00D, 1, 1,   1, 0, 32'h300, 32'h0,        32'hCAFEF00D, 0};
    vecs[3] = '{1, 0, 0, 32'h104, 32'h0,   32'h0,        32'h01234567, 5, 5,   0, 0, 32'h104, 32'h0,        32'h01234567, 0};
    vecs[4] = '{1, 1, 0, 32'h108, 32'h400, 32'h0,        32'h0BADC0DE, 3, 3,   1, 0, 32'h400, 32'h0,        32'h0BADC0DE, 0};
    vecs[5] = '{1, 0, 0, 32'h10C, 32'h0,   32'h0,        32'h99999999, 0, 255, 0, 0, 32'h10C, 32'h0,        32'h0BADC0DE, 1};
    vecs[6] = '{0, 1, 0, 32'h0,   32'h404, 32'h0,        32'h55AA55AA, 1, 1,   1, 0, 32'h404, 32'h0,        32'h55AA55AA, 0};
    vecs[7] = '{1, 1, 1, 32'h110, 32'h500, 32'hFEEDFACE, 32'h11111111, 2, 2,   1, 1, 32'h500, 32'hFEEDFACE, 32'h55AA55AA, 0};
    vecs[8] = '{1, 0, 0, 32'h114, 32'h0,   32'h0,        32'h22222222, 1, 1,   0, 0, 32'h114, 32'h0,        32'h22222222, 0};

    // Reset state, sampled while reset is held low.
    clear_inputs();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset mem_req", 64'(bus.mem_req), 64'(0));
    check("reset mem_we", 64'(bus.mem_we), 64'(0));
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset dones", 64'({bus.if_done, bus.ls_done}), 64'(0));
    check("reset err", 64'(bus.err), 64'(0));
    check("reset rdata", 64'(bus.rdata), 64'(0));
    check("reset mem_addr", 64'(bus.mem_addr), 64'(0));
    check("reset mux_sel", 64'(bus.mux_sel), 64'(0));
    check("reset state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("idle no req busy", 64'(bus.busy), 64'(0));

    for (int i = 0; i < 9; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i]);
    end

    // Both requesters held high: LS x4, then IF, repeating.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h1000;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 32'h2000;
    grants = 0;
    for (int c = 0; c < 200 && grants < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        got_own.push_back(bus.mux_sel);
        grants++;
        bus.mem_ready = 1'b1;
      end else begin
        bus.mem_ready = 1'b0;
      end
    end
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    for (int c = 0; c < 10 && (bus.busy || bus.mem_ready); c++) begin
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
    end
    check("starve grant count", 64'(grants), 64'(10));
    streak_m = 0;
    for (int g = 0; g < 10 && g < got_own.size(); g++) begin
      logic exp_own;
      if (streak_m == STARVE) begin
        exp_own  = OWNER_IF;
        streak_m = 0;
      end else begin
        exp_own  = OWNER_LS;
        streak_m = streak_m + 1;
      end
      check($sformatf("starve grant%0d owner", g), 64'(got_own[g]), 64'(exp_own));
    end

    // Reset asserted mid-ACCESS.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h500;
    @(posedge clk);
    #1;
    check("midreset access mem_req", 64'(bus.mem_req), 64'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midreset mem_req", 64'(bus.mem_req), 64'(0));
    check("midreset busy", 64'(bus.busy), 64'(0));
    check("midreset state", 64'(dbg_state), 64'(ST_IDLE));
    bus.if_req = 1'b0;
    done_cnt = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      done_cnt += int'(bus.if_done) + int'(bus.ls_done);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    done_cnt += int'(bus.if_done) + int'(bus.ls_done);
    check("midreset no done", 64'(done_cnt), 64'(0));
    check("midreset rdata cleared", 64'(bus.rdata), 64'(0));
    run_and_check("after_reset", '{1, 0, 0, 32'h600, 32'h0, 32'h0, 32'h600D600D, 2, 2, 0, 0, 32'h600, 32'h0, 32'h600D600D, 0});

    // Stray mem_ready in IDLE/RESP and ls_req dropped mid-ACCESS.
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hBAD0BAD0;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    check("stray ready idle busy", 64'(bus.busy), 64'(0));
    check("stray ready idle rdata", 64'(bus.rdata), 64'(32'h600D600D));
    bus.ls_req    = 1'b1;
    bus.ls_we     = 1'b0;
    bus.ls_addr   = 32'h700;
    bus.mem_rdata = 32'h77777777;
    @(posedge clk);
    #1;
    check("drop access mem_req", 64'(bus.mem_req), 64'(1));
    bus.ls_req  = 1'b0;
    bus.ls_addr = 32'h999;
    @(posedge clk);
    #1;
    check("drop addr held", 64'(bus.mem_addr), 64'(32'h700));
    check("drop still access", 64'(bus.mem_req), 64'(1));
    bus.mem_ready = 1'b1;
    done_cnt = 0;
    @(posedge clk);
    #1;
    done_cnt += int'(bus.ls_done);
    check("drop rdata", 64'(bus.rdata), 64'(32'h77777777));
    bus.mem_rdata = 32'hBAD0BAD0;
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      done_cnt += int'(bus.ls_done) + int'(bus.if_done);
    end
    check("drop ls_done once", 64'(done_cnt), 64'(1));
    check("stray ready resp rdata", 64'(bus.rdata), 64'(32'h77777777));
    check("drop idle busy", 64'(bus.busy), 64'(0));

    // Randomized transactions against a transaction-level model.
    apply_reset();
    streak_m = 0;
    rdata_m  = '0;
    for (int t = 0; t < 40; t++) begin
      logic        ireq, lreq, lwe, win_ls;
      logic [31:0] iaddr, laddr, lwdata, mrdata;
      int          k;
      vec_t        v;
      ireq   = 1'($urandom_range(0, 1));
      lreq   = 1'($urandom_range(0, 1));
      lwe    = 1'($urandom_range(0, 1));
      iaddr  = $urandom;
      laddr  = $urandom;
      lwdata = $urandom;
      mrdata = $urandom;
      k      = $urandom_range(1, 4);
      if (!ireq && !lreq) begin
        clear_inputs();
        @(posedge clk);
        #1;
        check($sformatf("rand%0d idle busy", t), 64'(bus.busy), 64'(0));
        continue;
      end
      win_ls = lreq && !(ireq && streak_m == STARVE);
      if (win_ls && ireq) streak_m = (streak_m < STARVE) ? streak_m + 1 : STARVE;
      else streak_m = 0;
      if (!(win_ls && lwe)) rdata_m = mrdata;
      exp_q.push_back(rdata_m);
      v = '{ireq, lreq, lwe, iaddr, laddr, lwdata, mrdata, k, k,
            win_ls, win_ls && lwe, win_ls ? laddr : iaddr, lwdata, exp_q.pop_front(), 0};
      run_and_check($sformatf("rand%0d", t), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
